// File: rtl/sample_deser_pkg.sv
// Shared definitions for the sample deserialiser: controller state encoding
// and frame geometry (slot count and slot-index width).
package sample_deser_pkg;

   localparam int SLOTS = 8;
   localparam int CNT_W = 3;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic logic is_last_slot(input logic [CNT_W-1:0] idx);
      return idx == LAST_SLOT;
   endfunction

endpackage

// File: rtl/sample_deser_ctrl.sv
// Frame controller: FILL/HOLD state machine, slot counter and the in/out
// handshakes. Emits a write strobe plus slot index for the datapath.
module sample_deser_ctrl
   import sample_deser_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_first,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             out_valid,
   output logic             wr_en,
   output logic [CNT_W-1:0] wr_slot,
   output logic             sa_load
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             xfer;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FILL;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wr_en     = 1'b0;
      wr_slot   = '0;
      sa_load   = 1'b0;
      out_valid = (state_q == ST_HOLD);
      // While holding, a sample can only enter on the edge that consumes the frame.
      in_ready  = !rst && ((state_q == ST_FILL) || out_ready);
      xfer      = in_valid && in_ready;

      case (state_q)
         ST_FILL: begin
            if (xfer) begin
               if (in_first) begin
                  wr_en   = 1'b1;
                  wr_slot = '0;
                  sa_load = 1'b1;
                  count_d = CNT_W'(1);
               end else if (count_q != '0) begin
                  wr_en   = 1'b1;
                  wr_slot = count_q;
                  if (is_last_slot(count_q)) begin
                     state_d = ST_HOLD;
                     count_d = '0;
                  end else begin
                     count_d = count_q + CNT_W'(1);
                  end
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_FILL;
               count_d = '0;
               if (xfer && in_first) begin
                  wr_en   = 1'b1;
                  wr_slot = '0;
                  sa_load = 1'b1;
                  count_d = CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_FILL;
            count_d = '0;
         end
      endcase
   end

endmodule

// File: rtl/sample_deser.sv
// Sample deserialiser: collects eight serial samples into a parallel frame
// (a..h) with the shift amount captured alongside slot 0.
module sample_deser #(
   parameter int WIDTH = 16,
   parameter int SLOTS = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_first,
   output logic             in_ready,
   input  logic [7:0]       in_sa,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] e,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] h,
   output logic [7:0]       sa,
   output logic             out_valid,
   input  logic             out_ready
);
   import sample_deser_pkg::*;

   logic             wr_en;
   logic [CNT_W-1:0] wr_slot;
   logic             sa_load;
   logic [SLOTS-1:0] slot_we;

   logic [WIDTH-1:0] slot_q [SLOTS];
   logic [WIDTH-1:0] slot_d [SLOTS];
   logic [7:0]       sa_q, sa_d;

   sample_deser_ctrl u_ctrl (
      .clk       (CLK),
      .rst       (RST),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .wr_en     (wr_en),
      .wr_slot   (wr_slot),
      .sa_load   (sa_load)
   );

   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_dec
         assign slot_we[gi] = wr_en && (wr_slot == CNT_W'(gi));
      end
   endgenerate

   // Unwritten slots simply hold; they are only observable once the frame completes.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         slot_d[i] = slot_we[i] ? in_data : slot_q[i];
      end
      sa_d = sa_load ? in_sa : sa_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < SLOTS; i++) begin
            slot_q[i] <= '0;
         end
         sa_q <= '0;
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            slot_q[i] <= slot_d[i];
         end
         sa_q <= sa_d;
      end
   end

   assign a  = slot_q[0];
   assign b  = slot_q[1];
   assign c  = slot_q[2];
   assign d  = slot_q[3];
   assign e  = slot_q[4];
   assign f  = slot_q[5];
   assign g  = slot_q[6];
   assign h  = slot_q[7];
   assign sa = sa_q;

endmodule

// File: tb/tb_sample_deser.sv
// Scoreboard bench for sample_deser: a queue-based frame model predicts
// frames, handshakes and out_valid; a negedge monitor compares.
module tb_sample_deser;
   localparam int W = 16;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic         RST = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_first = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_data = '0;
   logic [7:0]   in_sa = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] a, b, c, d, e, f, g, h;
   logic [7:0]   sa;

   sample_deser #(.WIDTH(W), .SLOTS(8)) dut (
      .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
      .in_first(in_first), .in_ready(in_ready), .in_sa(in_sa),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
      .sa(sa), .out_valid(out_valid), .out_ready(out_ready)
   );

   typedef struct packed {
      logic [7:0]        sa;
      logic [7:0][W-1:0] s;
   } frame_t;

   frame_t     exp_q[$];
   logic [W-1:0] part[$];
   logic [7:0] part_sa = '0;
   bit         pending = 1'b0;
   bit         mon_en = 1'b0;
   int         checks = 0;
   int         passes = 0;
   int         frames_seen = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endfunction

   // Monitor: handshake/valid prediction every cycle, frame compare on accept.
   always @(negedge CLK) begin
      if (mon_en) begin
         logic [W-1:0] act [8];
         frame_t       fr;
         check("in_ready", 32'(in_ready), 32'(!RST && (!pending || out_ready)));
         check("out_valid", 32'(out_valid), 32'(pending));
         if (out_valid && out_ready) begin
            check("frame_available", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
               fr = exp_q.pop_front();
               act = '{a, b, c, d, e, f, g, h};
               for (int i = 0; i < 8; i++)
                  check($sformatf("frame%0d_slot%0d", frames_seen, i), 32'(act[i]), 32'(fr.s[i]));
               check($sformatf("frame%0d_sa", frames_seen), 32'(sa), 32'(fr.sa));
               $display("frame %0d accepted: a=%h h=%h sa=%0d", frames_seen, a, h, sa);
               frames_seen++;
            end
         end
      end
   end

   // One clock of stimulus, followed by the reference-model update for that edge.
   task automatic step(input bit r, input bit v, input bit fst,
                       input logic [W-1:0] dat, input logic [7:0] s, input bit ordy);
      bit     rdy;
      frame_t fr;
      RST = r; in_valid = v; in_first = fst; in_data = dat; in_sa = s; out_ready = ordy;
      rdy = !r && (!pending || ordy);
      @(posedge CLK);
      #1;
      if (r) begin
         part.delete();
         exp_q.delete();
         pending = 1'b0;
      end else begin
         if (pending && ordy) pending = 1'b0;
         if (v && rdy) begin
            if (fst) begin
               part.delete();
               part.push_back(dat);
               part_sa = s;
            end else if (part.size() != 0) begin
               part.push_back(dat);
               if (part.size() == 8) begin
                  fr.sa = part_sa;
                  for (int i = 0; i < 8; i++) fr.s[i] = part[i];
                  exp_q.push_back(fr);
                  part.delete();
                  pending = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic send_frame(input logic [W-1:0] base, input logic [7:0] s, input bit ordy);
      for (int i = 0; i < 8; i++)
         step(1'b0, 1'b1, i == 0, base + W'(i), s, ordy);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   initial begin
      step(1'b1, 1'b1, 1'b1, 16'h1234, 8'h77, 1'b1);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_sa", 32'(sa), 32'd0);
      check("reset_a", 32'(a), 32'd0);
      check("reset_h", 32'(h), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd0);
      mon_en = 1'b1;

      // Basic 1..8 frame.
      send_frame(16'd1, 8'd3, 1'b1);
      idle(3);

      // Extreme sign patterns in slots 0 and 7.
      step(1'b0, 1'b1, 1'b1, 16'h8000, 8'd200, 1'b1);
      for (int i = 1; i < 7; i++) step(1'b0, 1'b1, 1'b0, W'($urandom), 8'd0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'd0, 1'b1);
      idle(2);

      // Backpressure while a frame is held, next frame's slot 0 waiting.
      send_frame(16'h0100, 8'd7, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 16'h1111, 8'd9, 1'b0);
      step(1'b0, 1'b1, 1'b1, 16'h1111, 8'd9, 1'b1);
      for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h1111 + W'(i), 8'd0, 1'b1);
      idle(2);

      // Back-to-back streaming, one frame per 8 cycles.
      for (int k = 0; k < 4; k++) send_frame(16'h2000 + W'(k * 16), 8'(k), 1'b1);
      idle(2);

      // Resync: in_first after 3 samples.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, i == 0, 16'h3000 + W'(i), 8'd1, 1'b1);
      send_frame(16'h4000, 8'd5, 1'b1);
      idle(2);

      // Reset pulsed mid-frame, then a fresh frame.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i == 0, 16'h5000 + W'(i), 8'd2, 1'b1);
      step(1'b1, 1'b1, 1'b0, 16'h5006, 8'd0, 1'b1);
      send_frame(16'h6000, 8'd11, 1'b1);
      idle(2);

      // Reset while a frame is held.
      send_frame(16'h7000, 8'd12, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      idle(2);

      // Randomised traffic.
      for (int n = 0; n < 1500; n++) begin
         bit r, v, fst, ordy;
         r    = ($urandom_range(0, 199) == 0);
         v    = ($urandom_range(0, 3) != 0);
         fst  = ($urandom_range(0, 13) == 0) || (part.size() == 0 && $urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         step(r, v, fst, W'($urandom), 8'($urandom), ordy);
      end
      idle(4);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("frames_seen_nonzero", 32'(frames_seen > 20), 32'd1);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
